mips32_mem_dump: RTL and testbench

Post-halt memory readout engine for the two-phase MIPS32 pipeline. It sits beside the processor's data memory. When the core asserts HALTED, it reads a programmed window of memory words through a synchronous read port. It then streams each word with its address over a valid/ready interface to a host, UART bridge or bench monitor. It is the reading counterpart of the program/data preload path: the preload path writes Mem before PC release, and this block reads results back after HLT.

---
 rtl/mips32_pkg.sv | 16 +
 rtl/mips32_mem_dump.sv | 148 ++++++++++++++
 tb/tb_mips32_mem_dump.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared sizing constants and types for the two-phase MIPS32 pipeline and the
// blocks that sit beside its data memory.
package mips32_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FIN     = 3'd4
  } dump_state_t;

endpackage

// File: rtl/mips32_mem_dump.sv
// Post-halt memory readout: on a rising HALTED edge, reads a window of data
// memory through a synchronous read port and streams (addr, word) over valid/ready.
module mips32_mem_dump
  import mips32_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              halted,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q, state_d;
  logic              halted_prev_q;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              trigger;
  logic [ADDR_W-1:0] next_addr;

  assign trigger   = halted && !halted_prev_q;
  assign next_addr = cur_addr_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // An empty window parks in IDLE for one cycle with busy set before FIN.
        if (busy_q) begin
          state_d = FIN;
        end else if (trigger) begin
          cur_addr_d  = base_addr;
          remaining_d = word_count;
          busy_d      = 1'b1;
          if (word_count != '0) begin
            state_d     = READ;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = base_addr;
          end
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        out_data_d  = mem_rd_data;
        out_addr_d  = cur_addr_q;
        out_last_d  = (remaining_q == (ADDR_W+1)'(1));
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          cur_addr_d  = next_addr;
          if (out_last_q) begin
            state_d = FIN;
          end else begin
            state_d     = READ;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = next_addr;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q       <= IDLE;
      halted_prev_q <= 1'b0;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_addr_q    <= '0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      halted_prev_q <= halted;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_addr_q    <= out_addr_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Self-checking bench for mips32_mem_dump: table-driven dumps, hand-written
// reset/retrigger sequences and randomized windows against an array model.
module tb_mips32_mem_dump;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk1 = 1'b0;
  logic          reset;
  logic          halted;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk1 = ~clk1;

  mips32_mem_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk1        (clk1),
    .reset       (reset),
    .halted      (halted),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  // Data memory with a one-cycle synchronous read port.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk1) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int cyc = 0;
  initial forever begin
    @(posedge clk1);
    cyc++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } xfer_t;

  xfer_t xq[$];
  int    done_cyc[$];
  int    rd_count   = 0;
  int    valid_seen = 0;

  // Monitor: samples on the falling edge, records transfers and checks that a
  // stalled word stays valid and unchanged.
  initial begin
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic [AW-1:0] prev_addr  = '0;
    logic          prev_last  = 1'b0;
    forever begin
      @(negedge clk1);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_addr", out_addr, prev_addr);
        check("hold_last", out_last, prev_last);
      end
      prev_stall = out_valid && !out_ready && !reset;
      prev_data  = out_data;
      prev_addr  = out_addr;
      prev_last  = out_last;
      if (out_valid && out_ready && !reset) xq.push_back('{out_addr, out_data, out_last});
      if (mem_rd_en) rd_count++;
      if (out_valid) valid_seen++;
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic clear_mon();
    xq.delete();
    done_cyc.delete();
    rd_count   = 0;
    valid_seen = 0;
  endtask

  int stall_cnt = 0;

  // mode 0: ready always high; 1: five low cycles inside each SEND; 2: random
  task automatic drive_ready(input int mode);
    case (mode)
      0: out_ready = 1'b1;
      1: begin
        if (out_valid) begin
          if (stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end else begin
          stall_cnt = 0;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Waits for done, then compares the stream with the window read from the model memory.
  task automatic await_and_check(input int base, input int count, input int mode,
                                 input int exp_ofs, input int trig, input bit glitch);
    int n;
    int a;
    n = 0;
    while (done_cyc.size() == 0 && n < count * 12 + 40) begin
      tick();
      n++;
      if (glitch && n == 4) halted = 1'b0;
      if (glitch && n == 5) halted = 1'b1;
      drive_ready(mode);
    end
    check("done_seen", done_cyc.size(), 1);
    if (done_cyc.size() > 0 && exp_ofs >= 0) check("done_cycle", done_cyc[0] - trig, exp_ofs);
    check("xfer_count", xq.size(), count);
    for (int i = 0; i < count && i < xq.size(); i++) begin
      a = (base + i) % DEPTH;
      check("xfer_addr", xq[i].addr, a);
      check("xfer_data", xq[i].data, mem[a]);
      check("xfer_last", xq[i].last, (i == count - 1));
    end
    check("rd_count", rd_count, count);
    if (count == 0) check("valid_seen", valid_seen, 0);
    $display("dump base=%0d count=%0d mode=%0d xfers=%0d", base, count, mode, xq.size());
    repeat (8) begin
      tick();
      drive_ready(2);
    end
    check("busy_after", busy, 0);
    check("no_redump", rd_count, count);
    check("done_once", done_cyc.size(), 1);
  endtask

  // Lowers halted for one cycle, raises it, and checks the resulting dump.
  task automatic run_dump(input int base, input int count, input int mode,
                          input int exp_ofs, input bit glitch);
    int trig;
    base_addr  = AW'(base);
    word_count = (AW+1)'(count);
    stall_cnt  = 0;
    halted     = 1'b0;
    drive_ready(mode);
    tick();
    clear_mon();
    halted = 1'b1;
    trig   = cyc + 1;
    drive_ready(mode);
    await_and_check(base, count, mode, exp_ofs, trig, glitch);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_addr"}, out_addr, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  typedef struct {
    int base;
    int count;
    int mode;
    int exp_done;
    bit glitch;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int trig;
    int n;
    int b;
    int c;
    int m;

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[198]  = 32'd5040;
    mem[199]  = 32'd0;
    mem[200]  = 32'd7;
    mem[1023] = 32'hDEADBEEF;
    mem[0]    = 32'h280a00c8;

    vecs[0] = '{198, 3, 0, 10, 1'b0};
    vecs[1] = '{198, 3, 1, -1, 1'b1};
    vecs[2] = '{5, 0, 0, 2, 1'b0};
    vecs[3] = '{1023, 2, 0, 7, 1'b0};
    vecs[4] = '{700, 1, 2, -1, 1'b0};
    vecs[5] = '{0, 1024, 0, 3073, 1'b0};

    reset      = 1'b1;
    halted     = 1'b0;
    out_ready  = 1'b0;
    base_addr  = '0;
    word_count = '0;
    repeat (3) tick();
    check_zero_outputs("rst");
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++)
      run_dump(vecs[v].base, vecs[v].count, vecs[v].mode, vecs[v].exp_done, vecs[v].glitch);

    // Halted held high after a dump: nothing more happens until it is seen low again.
    run_dump(198, 3, 0, 10, 1'b0);
    clear_mon();
    repeat (20) tick();
    check("hold_high_rd", rd_count, 0);
    check("hold_high_done", done_cyc.size(), 0);
    check("hold_high_busy", busy, 0);
    run_dump(198, 3, 0, 10, 1'b0);

    // Reset during the second word's SEND, then restart with halted still high.
    base_addr  = AW'(198);
    word_count = (AW+1)'(3);
    halted     = 1'b0;
    out_ready  = 1'b1;
    tick();
    clear_mon();
    halted = 1'b1;
    n = 0;
    while (!(out_valid && out_addr == AW'(199)) && n < 40) begin
      tick();
      n++;
    end
    check("reach_second_send", out_valid && out_addr == AW'(199), 1);
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();
    check_zero_outputs("midrst");
    check("midrst_no_done", done_cyc.size(), 0);
    reset = 1'b0;
    clear_mon();
    out_ready = 1'b1;
    stall_cnt = 0;
    trig      = cyc + 1;
    await_and_check(198, 3, 0, 10, trig, 1'b0);

    // Randomized windows against the array model.
    for (int r = 0; r < 8; r++) begin
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(0, 12);
      m = ($urandom_range(0, 1) == 0) ? 0 : 2;
      for (int k = 0; k < c; k++) mem[(b + k) % DEPTH] = $urandom;
      run_dump(b, c, m, (m == 0) ? ((c == 0) ? 2 : 3 * c + 1) : -1, c >= 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
